bg_line_fetcher: RTL and testbench

- Consumer and sequencer for a BG renderer's pixel interface. It produces the scan controls (oSTART, oLINE_START, oPIX_MOVE), issues oRGB_REQ, and captures iRGB_WRITE/iRGB_WRITE_DATA.
- Captured pixels go into a ping-pong line buffer: the fetcher fills line N+1 while the video output reads line N.
- Sits between one BG instance and the video timing/mixer output stage.

---
 rtl/bg_line_fetcher_pkg.sv | 18 +
 rtl/bg_line_fetcher_ram.sv | 27 ++
 rtl/bg_line_fetcher.sv | 142 ++++++++++++++
 tb/tb_bg_line_fetcher.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_line_fetcher_pkg.sv
// rtl/bg_line_fetcher_pkg.sv - video mixer shared types, screen geometry and fetch FSM states
package VidMixer;

   typedef logic [15:0] tRGB;

   localparam int cSCR_W = 320;
   localparam int cSCR_H = 240;

   typedef enum logic [2:0] {
      sIDLE,
      sINIT,
      sREQ,
      sWAIT,
      sMOVE,
      sDONE
   } tFETCH_STATE;

endpackage

// File: rtl/bg_line_fetcher_ram.sv
// rtl/bg_line_fetcher_ram.sv - ping-pong line buffer, one bank per line, registered read port
module bg_line_ram
   import VidMixer::*;
#(
   parameter int pLINE_W = cSCR_W
) (
   input  logic                         iCLOCK,
   input  logic                         iWE,
   input  logic                         iWR_BANK,
   input  logic [$clog2(pLINE_W)-1:0]   iWR_ADDR,
   input  logic [15:0]                  iWR_DATA,
   input  logic                         iRD_BANK,
   input  logic [$clog2(pLINE_W)-1:0]   iRD_ADDR,
   output logic [15:0]                  oRD_DATA
);

   // Addressed as {bank,x}, so each bank is padded up to a power of two.
   tRGB rMem [0:(2 << $clog2(pLINE_W))-1];

   always_ff @(posedge iCLOCK) begin
      if (iWE) begin
         rMem[{iWR_BANK, iWR_ADDR}] <= iWR_DATA;
      end
      oRD_DATA <= rMem[{iRD_BANK, iRD_ADDR}];
   end

endmodule

// File: rtl/bg_line_fetcher.sv
// rtl/bg_line_fetcher.sv - sequences BG pixel scan and fills the display ping-pong line buffer
module bg_line_fetcher
   import VidMixer::*;
#(
   parameter int pLINE_W = cSCR_W,
   parameter int pLINES  = cSCR_H
) (
   input  logic                         iCLOCK,
   input  logic                         iRESET_N,
   input  logic                         iFRAME_START,
   input  logic                         iDISP_LINE_START,
   input  logic [$clog2(pLINE_W)-1:0]   iDISP_RD_ADDR,
   output logic [15:0]                  oDISP_RGB,
   output logic                         oUNDERRUN,
   output logic                         oSTART,
   output logic                         oLINE_START,
   output logic                         oPIX_MOVE,
   output logic                         oRGB_REQ,
   input  logic                         iRGB_WRITE,
   input  logic [15:0]                  iRGB_WRITE_DATA
);

   localparam int cXW = $clog2(pLINE_W);
   localparam int cYW = $clog2(pLINES + 1);
   localparam logic [cXW-1:0] cX_LAST = cXW'(pLINE_W - 1);
   localparam logic [cYW-1:0] cY_END  = cYW'(pLINES);

   tFETCH_STATE rState, wNextState;
   logic [cXW-1:0] rX;
   logic [cYW-1:0] rY;
   logic rWrBank, rReady, rFramePend, rFirst;
   logic wCapture, wLastPix, wFrameTake, wLineSwap;

   assign wCapture   = (rState == sWAIT) && iRGB_WRITE;
   assign wLastPix   = (rX == cX_LAST);
   assign wLineSwap  = iDISP_LINE_START && rReady;
   // Restart only where no pixel handshake is outstanding.
   assign wFrameTake = rFramePend && (rState inside {sIDLE, sDONE, sMOVE});

   always_ff @(posedge iCLOCK or negedge iRESET_N) begin
      if (!iRESET_N) begin
         rState <= sIDLE;
      end else begin
         rState <= wNextState;
      end
   end

   always_comb begin
      wNextState = rState;
      unique case (rState)
         sIDLE: if (rFramePend) wNextState = sINIT;
         sINIT: wNextState = sREQ;
         sREQ:  wNextState = sWAIT;
         sWAIT: if (iRGB_WRITE) wNextState = sMOVE;
         sMOVE: begin
            if (wFrameTake)    wNextState = sINIT;
            else if (wLastPix) wNextState = sDONE;
            else               wNextState = sREQ;
         end
         sDONE: begin
            if (wFrameTake)   wNextState = sINIT;
            else if (!rReady) wNextState = (rY < cY_END) ? sINIT : sIDLE;
         end
         default: wNextState = sIDLE;
      endcase
   end

   always_comb begin
      oPIX_MOVE   = 1'b0;
      oSTART      = 1'b0;
      oLINE_START = 1'b0;
      oRGB_REQ    = 1'b0;
      case (rState)
         sINIT: begin
            oPIX_MOVE   = 1'b1;
            oSTART      = rFirst;
            oLINE_START = !rFirst;
         end
         sREQ:  oRGB_REQ  = 1'b1;
         sMOVE: oPIX_MOVE = 1'b1;
         default: ;
      endcase
   end

   // Banks are always complementary: display bank is ~rWrBank.
   always_ff @(posedge iCLOCK or negedge iRESET_N) begin
      if (!iRESET_N) begin
         rX         <= '0;
         rY         <= '0;
         rWrBank    <= 1'b0;
         rReady     <= 1'b0;
         rFramePend <= 1'b0;
         rFirst     <= 1'b0;
         oUNDERRUN  <= 1'b0;
      end else begin
         oUNDERRUN <= iDISP_LINE_START && !rReady;
         if (iFRAME_START) rFramePend <= 1'b1;
         if (wLineSwap) begin
            rWrBank <= ~rWrBank;
            rReady  <= 1'b0;
         end
         case (rState)
            sINIT: begin
               rX     <= '0;
               rFirst <= 1'b0;
            end
            sMOVE: begin
               if (!wFrameTake) begin
                  if (wLastPix) begin
                     rReady <= 1'b1;
                     rY     <= rY + 1'b1;
                  end else begin
                     rX <= rX + 1'b1;
                  end
               end
            end
            default: ;
         endcase
         // Evaluated after the line-start swap so a same-cycle swap still happens.
         if (wFrameTake) begin
            rFramePend <= 1'b0;
            rY         <= '0;
            rReady     <= 1'b0;
            rFirst     <= 1'b1;
         end
      end
   end

   bg_line_ram #(
      .pLINE_W (pLINE_W)
   ) uLineRam (
      .iCLOCK   (iCLOCK),
      .iWE      (wCapture),
      .iWR_BANK (rWrBank),
      .iWR_ADDR (rX),
      .iWR_DATA (iRGB_WRITE_DATA),
      .iRD_BANK (~rWrBank),
      .iRD_ADDR (iDISP_RD_ADDR),
      .oRD_DATA (oDISP_RGB)
   );

endmodule

// File: tb/tb_bg_line_fetcher.sv
// tb/tb_bg_line_fetcher.sv - directed bench for bg_line_fetcher with a latency renderer model
module tb_bg_line_fetcher;

   localparam int W  = 20;
   localparam int L  = 3;
   localparam int AW = $clog2(W);

   logic          iCLOCK = 1'b0;
   logic          iRESET_N = 1'b0;
   logic          iFRAME_START = 1'b0;
   logic          iDISP_LINE_START = 1'b0;
   logic [AW-1:0] iDISP_RD_ADDR = '0;
   logic [15:0]   oDISP_RGB;
   logic          oUNDERRUN, oSTART, oLINE_START, oPIX_MOVE, oRGB_REQ;
   logic          iRGB_WRITE = 1'b0;
   logic [15:0]   iRGB_WRITE_DATA = '0;

   bg_line_fetcher #(.pLINE_W(W), .pLINES(L)) dut (
      .iCLOCK           (iCLOCK),
      .iRESET_N         (iRESET_N),
      .iFRAME_START     (iFRAME_START),
      .iDISP_LINE_START (iDISP_LINE_START),
      .iDISP_RD_ADDR    (iDISP_RD_ADDR),
      .oDISP_RGB        (oDISP_RGB),
      .oUNDERRUN        (oUNDERRUN),
      .oSTART           (oSTART),
      .oLINE_START      (oLINE_START),
      .oPIX_MOVE        (oPIX_MOVE),
      .oRGB_REQ         (oRGB_REQ),
      .iRGB_WRITE       (iRGB_WRITE),
      .iRGB_WRITE_DATA  (iRGB_WRITE_DATA)
   );

   always #5 iCLOCK = ~iCLOCK;

   int nTests = 0;
   int nFail  = 0;

   int bx = 0, by = 0, lat = 5, pendCnt = 0, reqTotal = 0, reqSince = 0;
   bit hold = 1'b0;
   logic [15:0] pendData = '0;
   int qualQ[$];
   int lineReqQ[$];

   typedef struct {
      int            phase;
      logic [AW-1:0] addr;
      logic [15:0]   exp;
   } tRdVec;
   tRdVec vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic addVec(input int p, input int a, input int e);
      tRdVec v;
      v.phase = p;
      v.addr  = AW'(a);
      v.exp   = 16'(e);
      vecs.push_back(v);
   endtask

   task automatic pulseFrame();
      iFRAME_START = 1'b1;
      @(negedge iCLOCK);
      iFRAME_START = 1'b0;
   endtask

   task automatic pulseLine();
      iDISP_LINE_START = 1'b1;
      @(negedge iCLOCK);
      iDISP_LINE_START = 1'b0;
   endtask

   task automatic readPhase(input int p);
      foreach (vecs[k]) begin
         if (vecs[k].phase == p) begin
            iDISP_RD_ADDR = vecs[k].addr;
            @(negedge iCLOCK);
            check($sformatf("rd_p%0d_a%0d", p, vecs[k].addr), 32'(oDISP_RGB), 32'(vecs[k].exp));
         end
      end
   endtask

   task automatic waitPix(input int ln, input int tx, input string name);
      for (int i = 0; i < 3000 && !(by == ln && bx >= tx); i++) @(negedge iCLOCK);
      check(name, 32'(by == ln && bx >= tx), 32'd1);
   endtask

   // Renderer model: answers each request after lat cycles with x+y*1000.
   initial forever begin
      @(negedge iCLOCK);
      if (!iRESET_N) begin
         pendCnt    = 0;
         iRGB_WRITE = 1'b0;
      end else begin
         if (oPIX_MOVE) begin
            if (oSTART) begin
               bx = 0; by = 0; reqSince = 0;
               qualQ.push_back(1);
            end else if (oLINE_START) begin
               bx = 0; by++;
               qualQ.push_back(2);
               lineReqQ.push_back(reqSince);
               reqSince = 0;
            end else begin
               bx++;
            end
         end
         if (oRGB_REQ) begin
            reqTotal++; reqSince++;
            iRGB_WRITE = 1'b0;
            pendCnt    = lat;
            pendData   = 16'(bx + by * 1000);
         end else if (pendCnt > 0) begin
            pendCnt--;
            if (pendCnt == 0) begin
               iRGB_WRITE      = 1'b1;
               iRGB_WRITE_DATA = pendData;
            end
         end else if (!hold) begin
            iRGB_WRITE = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int reqBefore, plain, reqSeen;
      bit found;

      addVec(0, 17, 17);   addVec(0, 0, 0);       addVec(0, 19, 19);
      addVec(1, 3, 1003);  addVec(1, 17, 1017);   addVec(1, 19, 1019);
      addVec(2, 5, 1005);  addVec(2, 18, 1018);
      addVec(3, 5, 2005);  addVec(3, 0, 2000);
      addVec(4, 17, 17);   addVec(4, 1, 1);       addVec(4, 19, 19);
      addVec(5, 17, 17);   addVec(5, 2, 2);

      repeat (3) @(negedge iCLOCK);
      check("reset_outputs", 32'({oSTART, oLINE_START, oPIX_MOVE, oRGB_REQ, oUNDERRUN}), 32'd0);
      iRESET_N = 1'b1;
      repeat (10) @(negedge iCLOCK);
      check("idle_no_req", reqTotal, 0);
      pulseLine();
      check("early_underrun", 32'(oUNDERRUN), 32'd1);

      pulseFrame();
      for (int i = 0; i < 10 && !oPIX_MOVE; i++) @(negedge iCLOCK);
      check("first_move_start", 32'({oPIX_MOVE, oSTART, oLINE_START}), 32'b110);
      waitPix(0, W, "fill_line0");
      repeat (3) @(negedge iCLOCK);
      pulseLine();
      check("swap0_no_underrun", 32'(oUNDERRUN), 32'd0);
      readPhase(0);

      waitPix(1, W, "fill_line1");
      repeat (3) @(negedge iCLOCK);
      pulseLine();
      check("swap1_no_underrun", 32'(oUNDERRUN), 32'd0);
      readPhase(1);

      waitPix(2, 10, "mid_line2");
      pulseLine();
      check("underrun_pulse", 32'(oUNDERRUN), 32'd1);
      @(negedge iCLOCK);
      check("underrun_single", 32'(oUNDERRUN), 32'd0);
      readPhase(2);
      waitPix(2, W, "fill_line2");
      repeat (3) @(negedge iCLOCK);
      pulseLine();
      check("late_swap_no_underrun", 32'(oUNDERRUN), 32'd0);
      readPhase(3);

      repeat (40) @(negedge iCLOCK);
      check("frame_req_total", reqTotal, 3 * W);
      check("qual_seq", (qualQ.size() == 3) ? qualQ[0] * 100 + qualQ[1] * 10 + qualQ[2] : -1, 122);
      check("line_reqs", (lineReqQ.size() == 2) ? lineReqQ[0] * 100 + lineReqQ[1] : -1, W * 100 + W);

      hold = 1'b1;
      lat  = 1;
      pulseFrame();
      waitPix(0, W, "hold_fill_line0");
      repeat (3) @(negedge iCLOCK);
      pulseLine();
      check("hold_swap_no_underrun", 32'(oUNDERRUN), 32'd0);
      readPhase(4);

      hold = 1'b0;
      lat  = 5;
      waitPix(1, 5, "restart_reach_x5");
      for (int i = 0; i < 40 && !oRGB_REQ; i++) @(negedge iCLOCK);
      check("restart_saw_req", 32'(oRGB_REQ), 32'd1);
      @(negedge iCLOCK);
      pulseFrame();
      reqBefore = reqTotal;
      plain = 0; reqSeen = 0; found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (oPIX_MOVE && oSTART) begin
            found = 1'b1;
            break;
         end
         if (oPIX_MOVE) plain++;
         if (oRGB_REQ) reqSeen++;
         @(negedge iCLOCK);
      end
      check("restart_start_move", 32'(found), 32'd1);
      check("restart_pending_move", plain, 1);
      check("restart_no_req", reqSeen + (reqTotal - reqBefore), 0);
      waitPix(0, W, "restart_fill_line0");
      repeat (3) @(negedge iCLOCK);
      pulseLine();
      check("restart_swap_no_underrun", 32'(oUNDERRUN), 32'd0);
      readPhase(5);

      waitPix(1, 3, "reset_reach_mid");
      #2;
      iRESET_N = 1'b0;
      #1;
      check("async_reset_outputs", 32'({oSTART, oLINE_START, oPIX_MOVE, oRGB_REQ, oUNDERRUN}), 32'd0);
      #3;
      iRESET_N = 1'b1;
      reqBefore = reqTotal;
      repeat (20) @(negedge iCLOCK);
      check("post_reset_no_req", reqTotal - reqBefore, 0);
      pulseFrame();
      for (int i = 0; i < 10 && !oPIX_MOVE; i++) @(negedge iCLOCK);
      check("post_reset_start", 32'({oPIX_MOVE, oSTART}), 32'b11);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
